// File: rtl/cordic_range_ctrl.sv
// cordic_range_ctrl
// Front-end controller for the iterative CORDIC sine/cosine core.
// Reduces a full-circle Q3.16 angle into [-pi/2, pi/2], sequences the core's
// init/done handshake, applies the quadrant sign correction to the results
// and presents cosine/sine with a one-cycle valid pulse.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   start         - request, sampled only while idle
//   angle_in      - Q3.16 signed angle in radians (-4.0 .. +4.0)
//   cordic_cos    - Q2.16 cosine from the core
//   cordic_sin    - Q2.16 sine from the core
//   cordic_done   - core completion flag
//   cordic_angle  - Q2.16 reduced angle to the core's target_angle
//   cordic_init   - one-cycle init strobe to the core
//   cos_out       - Q2.16 corrected cosine (held until next capture)
//   sin_out       - Q2.16 corrected sine (held until next capture)
//   valid         - one-cycle pulse when cos_out/sin_out update
//   busy          - high whenever the controller is not idle
//   err           - one-cycle pulse when the core fails to finish in time
module cordic_range_ctrl #(
    parameter int unsigned TIMEOUT = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [18:0] angle_in,
    input  logic signed [17:0] cordic_cos,
    input  logic signed [17:0] cordic_sin,
    input  logic               cordic_done,
    output logic signed [17:0] cordic_angle,
    output logic               cordic_init,
    output logic signed [17:0] cos_out,
    output logic signed [17:0] sin_out,
    output logic               valid,
    output logic               busy,
    output logic               err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    // Angle constants in Q3.16 LSBs, carried at 20 bits for headroom
    localparam logic signed [19:0] PI          = 20'sd205887;
    localparam logic signed [19:0] NEG_PI      = -20'sd205887;
    localparam logic signed [19:0] HALF_PI     = 20'sd102944;
    localparam logic signed [19:0] NEG_HALF_PI = -20'sd102944;
    localparam logic signed [19:0] TWO_PI      = 20'sd411775;

    localparam logic signed [17:0] Q_MIN = 18'sh20000;
    localparam logic signed [17:0] Q_MAX = 18'sh1FFFF;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        INIT,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    logic signed [18:0] a;
    logic               neg;
    logic [CW-1:0]      cnt;

    logic signed [19:0] a_ext;
    logic signed [19:0] a1;
    logic signed [17:0] r;
    logic               neg_c;

    // Two-step range reduction: wrap into [-pi, pi], then fold into [-pi/2, pi/2]
    always_comb begin
        a_ext = {a[18], a};
        a1    = a_ext;
        if (a_ext > PI) begin
            a1 = a_ext - TWO_PI;
        end else if (a_ext < NEG_PI) begin
            a1 = a_ext + TWO_PI;
        end

        r     = 18'(a1);
        neg_c = 1'b0;
        if (a1 > HALF_PI) begin
            r     = 18'(a1 - PI);
            neg_c = 1'b1;
        end else if (a1 < NEG_HALF_PI) begin
            r     = 18'(a1 + PI);
            neg_c = 1'b1;
        end
    end

    // Quadrant correction; the most negative code saturates instead of wrapping
    function automatic logic signed [17:0] fix_sign(input logic signed [17:0] x,
                                                    input logic               n);
        if (!n) begin
            return x;
        end
        if (x == Q_MIN) begin
            return Q_MAX;
        end
        return -x;
    endfunction

    // Sequencer and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            a            <= '0;
            neg          <= 1'b0;
            cnt          <= '0;
            cordic_angle <= '0;
            cordic_init  <= 1'b0;
            cos_out      <= '0;
            sin_out      <= '0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            cordic_init <= 1'b0;
            valid       <= 1'b0;
            err         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= angle_in;
                        busy  <= 1'b1;
                        state <= REDUCE;
                    end
                end

                REDUCE: begin
                    cordic_angle <= r;
                    neg          <= neg_c;
                    cordic_init  <= 1'b1;
                    state        <= INIT;
                end

                INIT: begin
                    cnt   <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    // cnt == 0 marks the first WAIT cycle, where a stale done is ignored
                    if ((cnt != '0) && cordic_done) begin
                        cos_out <= fix_sign(cordic_cos, neg);
                        sin_out <= fix_sign(cordic_sin, neg);
                        valid   <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_range_ctrl.sv
// Testbench for cordic_range_ctrl: behavioural CORDIC core stand-in plus
// table-driven reduction vectors and hand-written handshake corner cases.
module tb_cordic_range_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [18:0] angle_in;
    logic signed [17:0] cordic_cos;
    logic signed [17:0] cordic_sin;
    logic               cordic_done;
    logic signed [17:0] cordic_angle;
    logic               cordic_init;
    logic signed [17:0] cos_out;
    logic signed [17:0] sin_out;
    logic               valid;
    logic               busy;
    logic               err;

    int checks   = 0;
    int failures = 0;

    // Core stand-in: outputs these values when it finishes
    int   core_c = 0;
    int   core_s = 0;
    logic hold_done = 1'b0;
    logic core_run = 1'b0;
    int   core_cnt = 0;

    cordic_range_ctrl #(.TIMEOUT(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .angle_in     (angle_in),
        .cordic_cos   (cordic_cos),
        .cordic_sin   (cordic_sin),
        .cordic_done  (cordic_done),
        .cordic_angle (cordic_angle),
        .cordic_init  (cordic_init),
        .cos_out      (cos_out),
        .sin_out      (sin_out),
        .valid        (valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Initialises on the edge that sees init, iterates 18 edges, done seen on the 19th
    initial begin
        cordic_done = 1'b0;
        cordic_cos  = '0;
        cordic_sin  = '0;
    end

    always @(posedge clk) begin
        if (cordic_init) begin
            core_run    <= 1'b1;
            core_cnt    <= 0;
            cordic_done <= 1'b0;
        end else if (core_run) begin
            if (core_cnt == 17) begin
                core_run <= 1'b0;
                if (!hold_done) begin
                    cordic_done <= 1'b1;
                    cordic_cos  <= 18'(core_c);
                    cordic_sin  <= 18'(core_s);
                end
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int angle;
        int cc;
        int cs;
        int exp_angle;
        int exp_cos;
        int exp_sin;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  seen;
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        angle_in = 19'(v.angle);
        core_c   = v.cc;
        core_s   = v.cs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({t, "_busy_rise"}, int'(busy), 1);
        @(posedge clk);
        #1;
        chk({t, "_angle"}, int'(cordic_angle), v.exp_angle);
        chk({t, "_init"}, int'(cordic_init), 1);
        n    = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) seen = 1;
        end
        chk({t, "_latency"}, n, 21);
        chk({t, "_cos"}, int'(cos_out), v.exp_cos);
        chk({t, "_sin"}, int'(sin_out), v.exp_sin);
        chk({t, "_busy_done"}, int'(busy), 1);
        @(posedge clk);
        #1;
        chk({t, "_valid_pulse"}, int'(valid), 0);
        chk({t, "_busy_fall"}, int'(busy), 0);
    endtask

    initial begin
        int vcount;
        int n;
        bit seen;

        vecs[0] = '{51472,   46341,   46341,   51472,   46341,   46341};
        vecs[1] = '{154415,  46341,  -46341,  -51472,  -46341,   46341};
        vecs[2] = '{-205887, 65536,   0,       0,      -65536,   0};
        vecs[3] = '{102944,  3,       65536,   102944,  3,       65536};
        vecs[4] = '{229376,  61372,   22989,   23488,  -61372,  -22989};
        vecs[5] = '{-102944, 3,      -65536,  -102944,  3,      -65536};
        vecs[6] = '{205887, -131072,  131071,  0,       131071, -131071};
        vecs[7] = '{-262144, 40000,  -30000,  -56256,  -40000,   30000};
        vecs[8] = '{262143,  1000,    2000,    56255,  -1000,   -2000};
        vecs[9] = '{102945,  5,      -65536,  -102942, -5,       65536};

        rst      = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_angle", int'(cordic_angle), 0);
        chk("rst_cos", int'(cos_out), 0);
        chk("rst_sin", int'(sin_out), 0);
        chk("rst_flags", int'({cordic_init, valid, busy, err}), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // start pulsed during WAIT is ignored; exactly one valid
        @(negedge clk);
        angle_in = 19'(0);
        core_c   = 65536;
        core_s   = 0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        vcount = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (valid) vcount++;
            if (i == 6) begin
                start    = 1'b1;
                angle_in = 19'(51472);
            end
        end
        start = 1'b0;
        chk("wait_start_valids", vcount, 1);
        chk("wait_start_cos", int'(cos_out), 65536);
        chk("wait_start_busy", int'(busy), 0);

        // reset at WAIT cycle 10
        @(negedge clk);
        angle_in = 19'(51472);
        core_c   = 46341;
        core_s   = 46341;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        #2;
        chk("midrst_cos", int'(cos_out), 0);
        chk("midrst_sin", int'(sin_out), 0);
        chk("midrst_angle", int'(cordic_angle), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst    = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (valid || err || busy) vcount++;
        end
        chk("midrst_quiet", vcount, 0);
        begin
            vec_t z;
            z = '{0, 65536, 0, 0, 65536, 0};
            run_vec(z, 10);
        end

        // start and rst together: reset wins
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        angle_in = 19'(51472);
        @(posedge clk);
        #1;
        chk("rst_start_busy", int'(busy), 0);
        chk("rst_start_angle", int'(cordic_angle), 0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start_idle", int'(busy), 0);

        // restore a known output value, then force a timeout
        begin
            vec_t z;
            z = '{0, 65536, 0, 0, 65536, 0};
            run_vec(z, 11);
        end
        hold_done = 1'b1;
        @(negedge clk);
        angle_in = 19'(51472);
        core_c   = 111;
        core_s   = 222;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        n      = 0;
        seen   = 0;
        vcount = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) vcount++;
            if (err) seen = 1;
        end
        chk("to_latency", n, 26);
        chk("to_no_valid", vcount, 0);
        chk("to_cos_held", int'(cos_out), 65536);
        chk("to_sin_held", int'(sin_out), 0);
        @(posedge clk);
        #1;
        chk("to_err_pulse", int'(err), 0);
        chk("to_busy_low", int'(busy), 0);
        chk("to_valid_low", int'(valid), 0);
        hold_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_range_ctrl.md
# cordic_range_ctrl

Front-end controller for the iterative CORDIC sine/cosine core. Accepts a full-circle angle, reduces it into the core's convergence range [-pi/2, pi/2] and sequences the core's `init`/`done` protocol. It then applies the quadrant sign correction to the core's results and presents cosine/sine with a one-cycle valid pulse. It sits directly upstream of the CORDIC core, and also registers that core's outputs.

## Interface
- `TIMEOUT`, 24: maximum cycles in WAIT before aborting. Must be at least 20.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `angle_in` in 19 signed: Q3.16 radians, bits [2:-16], full representable range -4.0 to +4.0.
- `cordic_cos` in 18 signed: Q2.16 cosine from the core.
- `cordic_sin` in 18 signed: Q2.16 sine from the core.
- `cordic_done` in 1: done flag from the core.
- `cordic_angle` out 18 signed: Q2.16 reduced angle to the core's `target_angle`.
- `cordic_init` out 1: drives the core's `init`.
- `cos_out` out 18 signed: Q2.16 corrected cosine.
- `sin_out` out 18 signed: Q2.16 corrected sine.
- `valid` out 1: one-cycle pulse when `cos_out`/`sin_out` are updated.
- `busy` out 1: high whenever state is not IDLE.
- `err` out 1: one-cycle pulse on a WAIT timeout.

## Operation
- Constants, in Q3.16 LSBs:
  - PI = 205887
  - HALF_PI = 102944
  - TWO_PI = 411775
- FSM states: IDLE, REDUCE, INIT, WAIT, DONE.
- IDLE:
  - On `start`, capture `angle_in` into register `a`.
  - Go to REDUCE.
- REDUCE, single cycle, 20-bit signed arithmetic:
  - Step 1: if a > PI, a1 = a - TWO_PI. If a < -PI, a1 = a + TWO_PI. Otherwise a1 = a.
  - One correction is sufficient for every representable input.
  - Step 2: if a1 > HALF_PI, r = a1 - PI and neg = 1. If a1 < -HALF_PI, r = a1 + PI and neg = 1. Otherwise r = a1 and neg = 0.
  - Exactly ±HALF_PI is not folded. Exactly ±PI folds to 0 with neg = 1.
  - Register r, truncated to 18 bits (always in range), into `cordic_angle`. Register `neg`.
  - Go to INIT.
- INIT:
  - `cordic_init` = 1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - `cordic_done` is ignored on the first WAIT cycle. It can still show a stale 1 from the previous run only if the core did not see init; the guard keeps behaviour robust.
  - From the second WAIT cycle on, `cordic_done` = 1 captures the results:
    - neg = 0: `cos_out` = `cordic_cos`, `sin_out` = `cordic_sin`.
    - neg = 1: both are two's-complement negated. Negating -131072 saturates to +131071.
    - Go to DONE.
  - Timeout counter reaches TIMEOUT with no done: pulse `err`, leave outputs unchanged, go to IDLE.
- DONE:
  - `valid` = 1 for this cycle.
  - Go to IDLE.
- `start` in any state other than IDLE is ignored. No queuing.
- `cos_out`/`sin_out` hold their value until the next successful capture.

## Timing
- Reset values:
  - State IDLE.
  - `cordic_angle`, `cos_out`, `sin_out` = 0.
  - `cordic_init`, `valid`, `busy`, `err` = 0.
  - `neg` and timeout counter = 0.
- All outputs are registered.
- Core handshake: the core initialises on the edge that ends INIT. It iterates on the next 18 edges. `cordic_done` is seen high on the 19th edge after the init edge.
- Latency, with `start` sampled at edge E0:
  - REDUCE after E0.
  - INIT after E1.
  - WAIT after E2.
  - Capture at E21.
  - `valid` high after E21 for one cycle.
  - IDLE after E22.
  - Start-to-valid is 21 cycles. The next `start` can be sampled at E23.
- `busy` rises after E0 and falls after E22.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs at reset values.
  - The core (no reset) may keep iterating. Its later `done` is ignored in IDLE.
  - The next INIT restarts it.
- `start` and `rst` asserted together: reset wins.

## Test plan
- `angle_in` = 51472 (pi/4) -> `cordic_angle` = 51472, neg = 0; 21 cycles later `valid`, `cos_out` ≈ `sin_out` ≈ 46341 ±16 LSB.
- `angle_in` = 154415 (3pi/4) -> `cordic_angle` = -51472, neg = 1; `cos_out` ≈ -46341, `sin_out` ≈ +46341 ±16.
- `angle_in` = -205887 (-pi) -> `cordic_angle` = 0; `cos_out` ≈ -65536 ±16, `sin_out` ≈ 0 ±16. `angle_in` = 102944 -> not folded, `cordic_angle` = 102944.
- `angle_in` = 229376 (3.5 rad) -> wrap, then fold; `cordic_angle` = 23488, neg = 1; `cos_out` ≈ -61375, `sin_out` ≈ -22990 ±16.
- `start` pulsed during WAIT -> ignored, single `valid`. Assert `rst` at cycle 10 of WAIT -> outputs zero, `busy` = 0, no `valid`. Then a new `start` with 0 -> `cos_out` ≈ 65536 at 21 cycles.
- Bench model holds `cordic_done` = 0 -> `err` pulses once TIMEOUT cycles after INIT, no `valid`, `cos_out`/`sin_out` unchanged, `busy` drops the next cycle.
